// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - shared phase encoding and level limits for the ADSR envelope
package adsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

    localparam int STATE_WIDTH = 3;

    function automatic int env_max(input int depth);
        return (1 << depth) - 1;
    endfunction

endpackage

// File: rtl/adsr_rate_accum.sv
// rtl/adsr_rate_accum.sv - fractional phase accumulator producing one Step per overflow
module adsr_rate_accum #(
    parameter int RATE_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Clear,
    input  logic [RATE_WIDTH-1:0] Rate,
    output logic                  Step
);

    logic [RATE_WIDTH-1:0] acc;
    logic [RATE_WIDTH-1:0] base;
    logic [RATE_WIDTH:0]   sum;

    // Clear restarts the phase from zero in the same cycle as the first add of
    // the new phase, so each phase's timing begins at its entry edge.
    always_comb begin
        base = Clear ? '0 : acc;
        sum  = {1'b0, base} + {1'b0, Rate};
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            acc  <= '0;
            Step <= 1'b0;
        end else begin
            acc  <= sum[RATE_WIDTH-1:0];
            Step <= sum[RATE_WIDTH];
        end
    end

endmodule

// File: rtl/adsr_env.sv
// rtl/adsr_env.sv - per-voice five-phase ADSR envelope generator feeding the VCA
module adsr_env
    import adsr_pkg::*;
#(
    parameter int WAVE_DEPTH = 8,
    parameter int RATE_WIDTH = 16
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   Gate,
    input  logic [RATE_WIDTH-1:0]  AttackRate,
    input  logic [RATE_WIDTH-1:0]  DecayRate,
    input  logic [WAVE_DEPTH-1:0]  Sustain,
    input  logic [RATE_WIDTH-1:0]  ReleaseRate,
    output logic [WAVE_DEPTH-1:0]  Envelope,
    output logic [STATE_WIDTH-1:0] State,
    output logic                   Active
);

    localparam logic [WAVE_DEPTH-1:0] ENV_MAX = WAVE_DEPTH'(env_max(WAVE_DEPTH));

    adsr_state_t           state;
    adsr_state_t           next_state;
    logic                  gate_q;
    logic                  rise;
    logic                  fall;
    logic                  transition;
    logic                  step;
    logic                  active_q;
    logic [WAVE_DEPTH-1:0] env;
    logic [WAVE_DEPTH-1:0] env_next;
    logic [RATE_WIDTH-1:0] rate_sel;

    assign rise = Gate & ~gate_q;
    assign fall = ~Gate & gate_q;

    // Gate edges outrank level-based exits; any phase change suppresses the step.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (rise) next_state = ST_ATTACK;
            ST_ATTACK:  if (fall) next_state = ST_RELEASE;
                        else if (env == ENV_MAX) next_state = ST_DECAY;
            ST_DECAY:   if (fall) next_state = ST_RELEASE;
                        else if (env <= Sustain) next_state = ST_SUSTAIN;
            ST_SUSTAIN: if (fall) next_state = ST_RELEASE;
            ST_RELEASE: if (rise) next_state = ST_ATTACK;
                        else if (env == '0) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    assign transition = (next_state != state);

    always_comb begin
        rate_sel = '0;
        case (next_state)
            ST_ATTACK:              rate_sel = AttackRate;
            ST_DECAY, ST_SUSTAIN:   rate_sel = DecayRate;
            ST_RELEASE:             rate_sel = ReleaseRate;
            default:                rate_sel = '0;
        endcase
    end

    adsr_rate_accum #(
        .RATE_WIDTH (RATE_WIDTH)
    ) u_rate_accum (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Clear   (transition),
        .Rate    (rate_sel),
        .Step    (step)
    );

    always_comb begin
        env_next = env;
        if (state == ST_IDLE) begin
            env_next = '0;
        end else if (!transition && step) begin
            case (state)
                ST_ATTACK:  if (env != ENV_MAX) env_next = env + 1'b1;
                ST_DECAY,
                ST_RELEASE: if (env != '0) env_next = env - 1'b1;
                ST_SUSTAIN: begin
                    if (env < Sustain)      env_next = env + 1'b1;
                    else if (env > Sustain) env_next = env - 1'b1;
                end
                default:    env_next = env;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            gate_q   <= 1'b0;
            state    <= ST_IDLE;
            env      <= '0;
            active_q <= 1'b0;
        end else begin
            gate_q   <= Gate;
            state    <= next_state;
            env      <= env_next;
            active_q <= (next_state != ST_IDLE);
        end
    end

    assign Envelope = env;
    assign State    = state;
    assign Active   = active_q;

endmodule

// File: tb/tb_adsr_env.sv
// tb/tb_adsr_env.sv - self-checking bench for adsr_env with a behavioural envelope model
module tb_adsr_env;

    localparam int WD   = 8;
    localparam int RW   = 8;
    localparam int EMAX = 255;
    localparam int MOD  = 256;

    logic          Clock;
    logic          Reset_n;
    logic          Gate;
    logic [RW-1:0] AttackRate;
    logic [RW-1:0] DecayRate;
    logic [WD-1:0] Sustain;
    logic [RW-1:0] ReleaseRate;
    logic [WD-1:0] Envelope;
    logic [2:0]    State;
    logic          Active;

    int errors = 0;
    int checks = 0;

    adsr_env #(.WAVE_DEPTH(WD), .RATE_WIDTH(RW)) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Gate        (Gate),
        .AttackRate  (AttackRate),
        .DecayRate   (DecayRate),
        .Sustain     (Sustain),
        .ReleaseRate (ReleaseRate),
        .Envelope    (Envelope),
        .State       (State),
        .Active      (Active)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Phase numbers: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
    typedef struct {
        int st;
        int env;
        int acc;
        int step;
        int gq;
    } mstate_t;

    mstate_t mdl;

    function automatic mstate_t model_next(mstate_t m, bit g, int ar, int dr, int su, int rr);
        mstate_t n = m;
        int  ns = m.st;
        int  rate;
        int  sum;
        bit  up = g && (m.gq == 0);
        bit  dn = !g && (m.gq != 0);
        if (up && (m.st == 0 || m.st == 4))                 ns = 1;
        else if (dn && m.st >= 1 && m.st <= 3)              ns = 4;
        else if (m.st == 1 && m.env == EMAX)                ns = 2;
        else if (m.st == 2 && m.env <= su)                  ns = 3;
        else if (m.st == 4 && m.env == 0)                   ns = 0;
        rate = (ns == 1) ? ar : (ns == 2 || ns == 3) ? dr : (ns == 4) ? rr : 0;
        n.gq = g ? 1 : 0;
        n.st = ns;
        if (ns != m.st) begin
            n.acc  = rate;
            n.step = 0;
        end else begin
            sum    = m.acc + rate;
            n.acc  = sum % MOD;
            n.step = sum / MOD;
            if (m.step != 0) begin
                if (m.st == 1)                    n.env = m.env + 1;
                else if (m.st == 2 || m.st == 4)  n.env = m.env - 1;
                else if (m.st == 3)               n.env = m.env + ((su > m.env) ? 1 : 0) - ((m.env > su) ? 1 : 0);
            end
            if (n.env > EMAX) n.env = EMAX;
            if (n.env < 0)    n.env = 0;
            if (m.st == 0)    n.env = 0;
        end
        return n;
    endfunction

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            mdl <= '{0, 0, 0, 0, 0};
        else
            mdl <= model_next(mdl, Gate, int'(AttackRate), int'(DecayRate), int'(Sustain), int'(ReleaseRate));
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clock);
        checks++;
        if ({Envelope, State, Active} !== {8'(mdl.env), 3'(mdl.st), (mdl.st != 0)}) begin
            errors++;
            $display("FAIL model t=%0t: env=%0d st=%0d act=%0d expected env=%0d st=%0d act=%0d",
                     $time, Envelope, State, Active, mdl.env, mdl.st, (mdl.st != 0));
        end
    endtask

    task automatic do_reset();
        Gate    = 1'b0;
        Reset_n = 1'b0;
        cyc();
        cyc();
        Reset_n = 1'b1;
        cyc();
    endtask

    task automatic set_rates(input int ar, input int dr, input int su, input int rr);
        AttackRate  = 8'(ar);
        DecayRate   = 8'(dr);
        Sustain     = 8'(su);
        ReleaseRate = 8'(rr);
    endtask

    typedef struct {
        int arate;
        int drate;
        int sus;
        int rrate;
        int hold;
        int exp_env;
        int exp_state;
    } vec_t;

    vec_t vt[6];

    initial begin
        int n;
        vt[0] = '{255, 255, 100, 255, 1000, 100, 3};
        vt[1] = '{128, 128, 200,  64, 1000, 200, 3};
        vt[2] = '{255, 200, 255, 128,  600, 255, 3};
        vt[3] = '{255,   0,  50, 255,  600, 255, 2};
        vt[4] = '{  0, 100, 100,  10,  300,   0, 1};
        vt[5] = '{255, 255,   0,  10,  800,   0, 3};

        // Asynchronous reset, including an abort in the middle of an attack
        Reset_n = 1'b0;
        Gate    = 1'b1;
        set_rates(255, 255, 100, 64);
        repeat (3) cyc();
        check("rst_env", int'(Envelope), 0);
        check("rst_state", int'(State), 0);
        check("rst_active", int'(Active), 0);
        Reset_n = 1'b1;
        for (int i = 0; i < 100 && Envelope < 10; i++) cyc();
        check("rst_attack_started", int'(Envelope >= 10 && State == 3'd1), 1);
        @(posedge Clock);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_async_env", int'(Envelope), 0);
        check("rst_async_state", int'(State), 0);
        check("rst_async_active", int'(Active), 0);
        cyc();
        Gate = 1'b0;
        cyc();
        Reset_n = 1'b1;
        cyc();

        // Table of settled-phase scenarios
        foreach (vt[i]) begin
            do_reset();
            set_rates(vt[i].arate, vt[i].drate, vt[i].sus, vt[i].rrate);
            Gate = 1'b1;
            repeat (vt[i].hold) cyc();
            check($sformatf("vec%0d_env", i), int'(Envelope), vt[i].exp_env);
            check($sformatf("vec%0d_state", i), int'(State), vt[i].exp_state);
            Gate = 1'b0;
            repeat (1200) cyc();
            check($sformatf("vec%0d_rel_state", i), int'(State), 0);
            check($sformatf("vec%0d_rel_env", i), int'(Envelope), 0);
        end

        // Full cycle timing
        do_reset();
        set_rates(128, 255, 100, 64);
        Gate = 1'b1;
        for (int i = 0; i < 5 && State != 3'd1; i++) cyc();
        check("full_attack_entry", int'(State), 1);
        n = 0;
        while (Envelope != 8'd255 && n < 2000) begin cyc(); n++; end
        check("full_attack_len", n, 510);
        for (int i = 0; i < 1000 && State != 3'd3; i++) cyc();
        check("full_sustain_state", int'(State), 3);
        check("full_sustain_env", int'(Envelope), 100);
        repeat (50) cyc();
        Gate = 1'b0;
        cyc();
        check("full_release_entry", int'(State), 4);
        n = 0;
        while (Envelope != 8'd0 && n < 1000) begin cyc(); n++; end
        check("full_release_len", n, 400);
        cyc();
        check("full_idle", int'(State), 0);
        check("full_idle_active", int'(Active), 0);

        // Early release from the middle of an attack
        do_reset();
        set_rates(128, 255, 100, 64);
        Gate = 1'b1;
        for (int i = 0; i < 200 && Envelope != 8'd40; i++) cyc();
        check("early_reach40", int'(Envelope), 40);
        Gate = 1'b0;
        cyc();
        check("early_state", int'(State), 4);
        check("early_env", int'(Envelope), 40);
        repeat (8) cyc();
        check("early_env_after8", int'(Envelope), 38);

        // Retrigger during release continues from the current level
        do_reset();
        set_rates(255, 255, 100, 64);
        Gate = 1'b1;
        for (int i = 0; i < 1000 && State != 3'd3; i++) cyc();
        Gate = 1'b0;
        for (int i = 0; i < 300 && Envelope != 8'd70; i++) cyc();
        check("retrig_rel_state", int'(State), 4);
        check("retrig_rel_env", int'(Envelope), 70);
        Gate = 1'b1;
        cyc();
        check("retrig_state", int'(State), 1);
        check("retrig_env", int'(Envelope), 70);
        repeat (2) cyc();
        check("retrig_env_first_step", int'(Envelope), 71);
        repeat (10) cyc();
        check("retrig_env_later", int'(Envelope), 81);

        // Live sustain tracking and saturation corners
        do_reset();
        set_rates(255, 255, 100, 255);
        Gate = 1'b1;
        for (int i = 0; i < 1000 && State != 3'd3; i++) cyc();
        check("live_sus_env100", int'(Envelope), 100);
        Sustain = 8'd150;
        repeat (300) cyc();
        check("live_sus_state", int'(State), 3);
        check("live_sus_env150", int'(Envelope), 150);
        Sustain = 8'd255;
        repeat (300) cyc();
        check("live_sus_env255", int'(Envelope), 255);
        check("live_sus_state255", int'(State), 3);
        Gate = 1'b0;
        for (int i = 0; i < 600 && State != 3'd0; i++) cyc();
        check("live_idle_state", int'(State), 0);
        repeat (20) cyc();
        check("live_idle_env", int'(Envelope), 0);
        AttackRate = 8'd0;
        Gate = 1'b1;
        repeat (100) cyc();
        check("zero_attack_state", int'(State), 1);
        check("zero_attack_env", int'(Envelope), 0);

        // Fall in the cycle Envelope sits at max: release wins over decay
        do_reset();
        set_rates(255, 255, 100, 64);
        Gate = 1'b1;
        for (int i = 0; i < 600 && Envelope != 8'd255; i++) cyc();
        check("simul_at_max_state", int'(State), 1);
        Gate = 1'b0;
        cyc();
        check("simul_state", int'(State), 4);
        check("simul_env", int'(Envelope), 255);

        // Randomised gate patterns and rates against the model
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            int dur;
            set_rates($urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(1, 255));
            Gate = ~Gate;
            dur  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(20, 400);
            for (int k = 0; k < dur; k++) begin
                if ($urandom_range(0, 63) == 0) Sustain = 8'($urandom_range(0, 255));
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
